// File: rtl/tdm_mux_demux.sv
// Time-division multiplexer/demultiplexer: scans CANAIS channels onto one shared link and rebuilds them in registers.
// Optional build macro TDM_FRAME_CNT_EN adds an 8-bit completed-frame counter output n_quadros.
module tdm_mux_demux #(
    parameter int CANAIS  = 4,
    parameter int LARGURA = 1,
    parameter int SEL_W   = $clog2(CANAIS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        modo,
    input  logic [SEL_W-1:0]            S_manual,
    input  logic [CANAIS*LARGURA-1:0]   D,
    output logic [SEL_W-1:0]            S,
    output logic [LARGURA-1:0]          ligacao,
    output logic [CANAIS*LARGURA-1:0]   Y,
`ifdef TDM_FRAME_CNT_EN
    output logic [7:0]                  n_quadros,
`endif
    output logic                        quadro
);

    localparam logic [SEL_W-1:0] ULTIMO = SEL_W'(CANAIS - 1);

    logic             wrap;
    logic [SEL_W-1:0] s_next;

    // An out-of-range slot never matches any channel, so the link reads 0.
    always_comb begin
        ligacao = '0;
        for (int k = 0; k < CANAIS; k++) begin
            if (S == SEL_W'(k)) begin
                ligacao = D[k*LARGURA +: LARGURA];
            end
        end
    end

    assign wrap = !modo && (S == ULTIMO);

    // Any slot at or beyond the last one (including an invalid manual slot) restarts at 0.
    always_comb begin
        s_next = '0;
        if (modo) begin
            s_next = S_manual;
        end else if (S >= ULTIMO) begin
            s_next = '0;
        end else begin
            s_next = S + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S      <= '0;
            quadro <= 1'b0;
        end else if (en) begin
            S      <= s_next;
            quadro <= wrap;
        end else begin
            quadro <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y <= '0;
        end else if (en) begin
            for (int k = 0; k < CANAIS; k++) begin
                if (S == SEL_W'(k)) begin
                    Y[k*LARGURA +: LARGURA] <= ligacao;
                end
            end
        end
    end

`ifdef TDM_FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_quadros <= 8'd0;
        end else if (en && wrap) begin
            n_quadros <= n_quadros + 8'd1;
        end
    end
`endif

endmodule
